// File: rtl/handshake_fifo_buffer.sv
// Elastic multi-slot FIFO for the dataflow handshake fabric.
// Every handshake output comes from registered state, so valid and ready are decoupled.
module handshake_fifo_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLOTS  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ins,
    input  logic                  ins_valid,
    output logic                  ins_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready
);
    localparam int PTR_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int CNT_W = $clog2(NUM_SLOTS + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_SLOTS - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_SLOTS);

    logic [DATA_WIDTH-1:0] mem_q [NUM_SLOTS];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  push, pop;

    // Explicit wrap so non-power-of-two depths never index past the last slot.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign ins_ready  = (count_q != FULL_CNT);
    assign outs_valid = (count_q != '0);
    assign outs       = mem_q[rd_ptr_q];
    assign push       = ins_valid & ins_ready;
    assign pop        = outs_valid & outs_ready;

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = next_ptr(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from pre-edge values.
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: slot storage is deliberately not reset; count gates whether its contents are visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= ins;
        end
    end
endmodule

// File: tb/tb_handshake_fifo_buffer.sv
// Scoreboard bench: lane 0 is a 2-slot buffer (directed tests), lane 1 a 3-slot buffer (random flow).
// A queue-based reference model predicts occupancy, readiness and token order.
module tb_handshake_fifo_buffer;
    logic        clk;
    logic        rst;
    logic [11:0] ins        [2];
    logic        ins_valid  [2];
    logic        ins_ready  [2];
    logic [11:0] outs       [2];
    logic        outs_valid [2];
    logic        outs_ready [2];

    logic [11:0] exp_q [2][$];
    bit          pushed   [2] = '{0, 0};
    bit          room     [2] = '{1, 1};
    int          push_cnt [2] = '{0, 0};
    int          pop_cnt  [2] = '{0, 0};
    int          checks = 0;
    int          errors = 0;

    handshake_fifo_buffer #(.DATA_WIDTH(12), .NUM_SLOTS(2)) u_dut_s2 (
        .clk(clk), .rst(rst),
        .ins(ins[0]), .ins_valid(ins_valid[0]), .ins_ready(ins_ready[0]),
        .outs(outs[0]), .outs_valid(outs_valid[0]), .outs_ready(outs_ready[0])
    );

    handshake_fifo_buffer #(.DATA_WIDTH(12), .NUM_SLOTS(3)) u_dut_s3 (
        .clk(clk), .rst(rst),
        .ins(ins[1]), .ins_valid(ins_valid[1]), .ins_ready(ins_ready[1]),
        .outs(outs[1]), .outs_valid(outs_valid[1]), .outs_ready(outs_ready[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int cap(input int d);
        return (d == 0) ? 2 : 3;
    endfunction

    task automatic check(input string name, input int lane, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s lane%0d: got %0h expected %0h at %0t", name, lane, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model, producer side: a token enters when offered and the model had room.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                exp_q[d].delete();
                pushed[d] = 1'b0;
                room[d]   = 1'b1;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                pushed[d] = ins_valid[d] && room[d];
                if (pushed[d]) begin
                    exp_q[d].push_back(ins[d]);
                    push_cnt[d]++;
                end
            end
        end
    end

    // Monitor: compare handshake outputs with the model, pop whenever the consumer takes the head.
    always @(negedge clk) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                int sz;
                logic [11:0] exp_tok;
                sz = exp_q[d].size();
                check("outs_valid", d, outs_valid[d], sz > 0);
                check("ins_ready", d, ins_ready[d], sz < cap(d));
                room[d] = (sz < cap(d));
                if (outs_valid[d] && outs_ready[d]) begin
                    if (sz == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL pop_empty lane%0d: got token %0h expected none", d, outs[d]);
                    end else begin
                        exp_tok = exp_q[d].pop_front();
                        check("outs_data", d, outs[d], exp_tok);
                        pop_cnt[d]++;
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base_push, base_pop, full_tick, stalls, sent, cycles;

        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            ins[d] = '0;
            ins_valid[d] = 1'b0;
            outs_ready[d] = 1'b0;
        end
        #1 rst = 1'b0;
        #2;
        for (int d = 0; d < 2; d++) begin
            check("rst_outs_valid", d, outs_valid[d], 1'b0);
            check("rst_ins_ready", d, ins_ready[d], 1'b1);
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_valid", 0, outs_valid[0], 1'b0);
        @(negedge clk);
        #1 rst = 1'b1;

        // Single token: visible one cycle after the push, gone the cycle after.
        tick();
        ins[0] = 12'hF32; ins_valid[0] = 1'b1; outs_ready[0] = 1'b1;
        tick();
        ins_valid[0] = 1'b0;
        check("t1_valid", 0, outs_valid[0], 1'b1);
        check("t1_data", 0, outs[0], 12'hF32);
        tick();
        check("t1_empty", 0, outs_valid[0], 1'b0);

        // Fill to full with the consumer stalled, then drain.
        outs_ready[0] = 1'b0;
        ins[0] = 12'h001; ins_valid[0] = 1'b1;
        tick();
        ins[0] = 12'h002;
        tick();
        ins[0] = 12'h003;
        check("t2_full", 0, ins_ready[0], 1'b0);
        tick();
        check("t2_still_full", 0, ins_ready[0], 1'b0);
        check("t2_head1", 0, outs[0], 12'h001);
        outs_ready[0] = 1'b1;
        tick();
        check("t2_head2", 0, outs[0], 12'h002);
        check("t2_ready_back", 0, ins_ready[0], 1'b1);
        tick();
        ins_valid[0] = 1'b0;
        check("t2_head3", 0, outs[0], 12'h003);
        check("t2_valid3", 0, outs_valid[0], 1'b1);
        tick();
        check("t2_drained", 0, outs_valid[0], 1'b0);
        outs_ready[0] = 1'b0;

        // Continuous streaming of 0..99: one fill cycle, then one token per cycle.
        base_push = push_cnt[0];
        base_pop  = pop_cnt[0];
        full_tick = -1;
        stalls    = 0;
        ins[0] = 12'd0; ins_valid[0] = 1'b1; outs_ready[0] = 1'b1;
        for (int k = 0; k <= 100; k++) begin
            tick();
            if (ins_ready[0] !== 1'b1) stalls++;
            if (ins_valid[0] && pushed[0]) begin
                if (push_cnt[0] - base_push < 100) begin
                    ins[0] = 12'(push_cnt[0] - base_push);
                end else begin
                    ins_valid[0] = 1'b0;
                    full_tick = k;
                end
            end
        end
        check("t3_push_tick", 0, full_tick, 99);
        check("t3_tokens_out", 0, pop_cnt[0] - base_pop, 100);
        check("t3_no_stall", 0, stalls, 0);
        check("t3_empty_end", 0, outs_valid[0], 1'b0);
        outs_ready[0] = 1'b0;

        // Simultaneous push and pop at occupancy 1.
        ins[0] = 12'h5A5; ins_valid[0] = 1'b1;
        tick();
        ins[0] = 12'h3C3; outs_ready[0] = 1'b1;
        tick();
        ins_valid[0] = 1'b0; outs_ready[0] = 1'b0;
        check("t5_valid", 0, outs_valid[0], 1'b1);
        check("t5_data", 0, outs[0], 12'h3C3);
        check("t5_ready", 0, ins_ready[0], 1'b1);
        tick();
        check("t5_count_one", 0, outs_valid[0], 1'b1);
        outs_ready[0] = 1'b1;
        tick();
        outs_ready[0] = 1'b0;
        check("t5_drained", 0, outs_valid[0], 1'b0);

        // Random flow through the 3-slot buffer, 1000 tokens.
        sent   = 0;
        cycles = 0;
        base_pop = pop_cnt[1];
        while ((pop_cnt[1] - base_pop < 1000) && (cycles < 20000)) begin
            if (ins_valid[1] && pushed[1]) sent++;
            if (!ins_valid[1] || pushed[1]) begin
                if ((sent < 1000) && ($urandom_range(0, 1) == 1)) begin
                    ins_valid[1] = 1'b1;
                    ins[1] = 12'($urandom);
                end else begin
                    ins_valid[1] = 1'b0;
                end
            end
            outs_ready[1] = ($urandom_range(0, 1) == 1);
            tick();
            cycles++;
        end
        ins_valid[1] = 1'b0;
        outs_ready[1] = 1'b0;
        check("t4_tokens_out", 1, pop_cnt[1] - base_pop, 1000);

        // Reset between edges with two tokens stored.
        ins[0] = 12'h111; ins_valid[0] = 1'b1;
        tick();
        ins[0] = 12'h222;
        tick();
        ins_valid[0] = 1'b0;
        check("t6_full", 0, ins_ready[0], 1'b0);
        #2 rst = 1'b0;
        #1;
        check("t6_async_valid", 0, outs_valid[0], 1'b0);
        check("t6_async_ready", 0, ins_ready[0], 1'b1);
        @(negedge clk);
        #1 rst = 1'b1;
        tick();
        ins[0] = 12'h0AB; ins_valid[0] = 1'b1; outs_ready[0] = 1'b1;
        tick();
        ins_valid[0] = 1'b0;
        check("t6_first_valid", 0, outs_valid[0], 1'b1);
        check("t6_first_data", 0, outs[0], 12'h0AB);
        tick();
        check("t6_empty", 0, outs_valid[0], 1'b0);
        outs_ready[0] = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/handshake_fifo_buffer.md
# handshake_fifo_buffer

Elastic multi-slot FIFO buffer for the dataflow handshake fabric. It sits directly downstream of constant, operator and fork outputs, for example between a control-triggered constant stage and the arithmetic unit that consumes it. It absorbs back-pressure and decouples the valid and ready paths on both sides. All handshake outputs depend only on internal registers, so no combinational path runs through the block.

## Interface
Parameters:
- DATA_WIDTH, 32, payload width in bits (≥1).
- NUM_SLOTS, 2, storage depth in tokens (≥1; non-power-of-two allowed).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-low; asserted at 0, released at 1.
- ins  input  DATA_WIDTH  input payload.
- ins_valid  input  1  input token present.
- ins_ready  output  1  buffer can accept a token this cycle.
- outs  output  DATA_WIDTH  output payload (head slot).
- outs_valid  output  1  head token present.
- outs_ready  input  1  consumer accepts the head token this cycle.

## Operation
State:
- Slot array mem[NUM_SLOTS] of DATA_WIDTH bits; not reset.
- Write pointer wr_ptr and read pointer rd_ptr, each clog2(NUM_SLOTS) bits, minimum 1 bit.
- Occupancy count, clog2(NUM_SLOTS+1) bits.

Output and handshake equations:
- empty = (count == 0); full = (count == NUM_SLOTS).
- ins_ready = !full. It is derived from registered state only and is never a function of outs_ready.
- outs_valid = !empty; outs = mem[rd_ptr].
- push = ins_valid & ins_ready; pop = outs_valid & outs_ready.

Updates on each rising edge:
- Push writes mem[wr_ptr] = ins and advances wr_ptr.
- Pop advances rd_ptr.
- Pointer wrap: if ptr == NUM_SLOTS-1 it becomes 0, else ptr+1. This is an explicit compare, not power-of-two truncation.
- count: +1 on push only, −1 on pop only, unchanged on both or neither.

Boundary conditions:
- Full: ins_ready = 0, so no push occurs, even if a pop happens the same cycle. ins_ready returns to 1 on the cycle after the pop.
- Empty: outs_valid = 0 and no pop is possible. A token pushed into an empty buffer becomes visible on the next cycle, with no fall-through.
- Simultaneous push and pop when partially full: both are performed, count holds, and both pointers advance.
- Token order is strict FIFO. Tokens are never dropped or duplicated.
- When outs_valid = 0, outs is don't-care and must not be checked.
- Producer obligation: once ins_valid is raised it is held with ins stable until push. The buffer itself holds outs and outs_valid stable while outs_valid & !outs_ready.

Reset:
- Asserting rst = 0 at any time, including mid-transfer, immediately clears count, wr_ptr and rd_ptr.
- Outputs go to outs_valid = 0 and ins_ready = 1, asynchronously.
- Stored tokens are discarded.
- Normal operation resumes on the first rising edge after release.

## Timing
- Latency: a token accepted at edge N appears on outs with outs_valid = 1 after edge N (visible in cycle N+1). Minimum latency is 1 cycle.
- Throughput: 1 token/cycle sustained when NUM_SLOTS ≥ 2.
- With NUM_SLOTS = 1, throughput is 1 token per 2 cycles under continuous flow, because full blocks a same-cycle refill.
- ins_ready reacts to a pop with a 1-cycle delay.
- outs_valid reacts to a push with a 1-cycle delay.
- Reset is asynchronous on assertion. Release is sampled by clk; the integrator provides a synchronized deassertion.

## Test plan
1. Reset and single token:
   - Stimulus: hold rst = 0, check outputs, release, then push ins = 12'hF32 (DATA_WIDTH = 12, NUM_SLOTS = 2) with outs_ready = 1.
   - Required: during reset outs_valid = 0 and ins_ready = 1. outs_valid = 1 with outs = 12'hF32 exactly one cycle after the push, and 0 the cycle after.
2. Fill to full:
   - Stimulus: outs_ready = 0, offer 0x001, 0x002, 0x003 on consecutive cycles.
   - Required: first two accepted; ins_ready = 0 from the cycle after the second push; 0x003 is held, not accepted.
   - Then raise outs_ready: outs reads 0x001 then 0x002, and 0x003 is accepted the cycle after the first pop.
3. Continuous streaming:
   - Stimulus: NUM_SLOTS = 2, ins_valid = outs_ready = 1, values 0..99.
   - Required: after a 1-cycle fill, 1 token/cycle in order; no bubbles; count never exceeds 1.
4. Wrap-around, non-power-of-two:
   - Stimulus: NUM_SLOTS = 3, random valid/ready at 50% each, 1000 tokens.
   - Required: a scoreboard sees an in-order, lossless sequence; count never exceeds 3; ins_ready is never 1 while count = 3.
5. Simultaneous push and pop at partial occupancy:
   - Stimulus: count = 1, push and pop in the same cycle.
   - Required: count stays 1; the next outs is the newly pushed value.
6. Reset mid-operation:
   - Stimulus: with 2 tokens stored and outs_ready = 0, assert rst = 0 between clock edges.
   - Required: outs_valid drops to 0 without waiting for an edge; after release, the first new token pushed is the first one output.
